// File: rtl/ctrl_hazard_unit.sv
// rtl/ctrl_hazard_unit.sv - MIPS D-stage decode, stall and forwarding control with E/M/W shadow tracking.
// Optional stall statistics counter: define CTRL_HAZ_STATS_EN.
module ctrl_hazard_unit #(
  parameter int ADDR_W    = 5,
  parameter int TNEW_W    = 2,
  parameter int ALU_TNEW  = 1,
  parameter int LOAD_TNEW = 2,
  parameter int TUSE_NONE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Instr_D,
  input  logic              flush_E,
  output logic              stall_D,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic [ADDR_W-1:0] A3_D,
  output logic [31:0]       stall_cnt
);

  localparam logic [TNEW_W-1:0] T_ALU  = TNEW_W'(ALU_TNEW);
  localparam logic [TNEW_W-1:0] T_LOAD = TNEW_W'(LOAD_TNEW);
  localparam logic [TNEW_W-1:0] T_NONE = TNEW_W'(TUSE_NONE);
  localparam logic [TNEW_W-1:0] T_ZERO = '0;
  localparam logic [TNEW_W-1:0] T_ONE  = TNEW_W'(1);
  localparam logic [TNEW_W-1:0] T_TWO  = TNEW_W'(2);

  logic [5:0]        op, funct;
  logic [ADDR_W-1:0] rs_d, rt_d, rd_d, a3_d;
  logic [TNEW_W-1:0] tuse_rs, tuse_rt, tnew_d;
  logic              unused_shamt;

  assign op    = Instr_D[31:26];
  assign funct = Instr_D[5:0];
  assign rs_d  = ADDR_W'(Instr_D[25:21]);
  assign rt_d  = ADDR_W'(Instr_D[20:16]);
  assign rd_d  = ADDR_W'(Instr_D[15:11]);
  assign unused_shamt = ^Instr_D[10:6];

  always_comb begin
    tuse_rs = T_NONE;
    tuse_rt = T_NONE;
    tnew_d  = T_ZERO;
    a3_d    = '0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100001, 6'b100011: begin
            tuse_rs = T_ONE;
            tuse_rt = T_ONE;
            tnew_d  = T_ALU;
            a3_d    = rd_d;
          end
          6'b001000: tuse_rs = T_ZERO;
          6'b001001: begin
            tuse_rs = T_ZERO;
            tnew_d  = T_ZERO;
            a3_d    = rd_d;
          end
          default: ;
        endcase
      end
      6'b001101, 6'b001000: begin
        tuse_rs = T_ONE;
        tnew_d  = T_ALU;
        a3_d    = rt_d;
      end
      6'b001111: begin
        tnew_d = T_ALU;
        a3_d   = rt_d;
      end
      6'b100011: begin
        tuse_rs = T_ONE;
        tnew_d  = T_LOAD;
        a3_d    = rt_d;
      end
      6'b101011: begin
        tuse_rs = T_ONE;
        tuse_rt = T_TWO;
      end
      6'b000100, 6'b111100: begin
        tuse_rs = T_ZERO;
        tuse_rt = T_ZERO;
      end
      6'b000011: begin
        tnew_d = T_ZERO;
        a3_d   = ADDR_W'(31);
      end
      default: ;
    endcase
  end

  logic [ADDR_W-1:0] a3_e, a3_m, a3_w, rs_e, rt_e;
  logic [TNEW_W-1:0] tnew_e, tnew_m, tnew_w;

  function automatic logic [TNEW_W-1:0] age(input logic [TNEW_W-1:0] t);
    return (t == T_ZERO) ? T_ZERO : t - T_ONE;
  endfunction

  function automatic logic hit(input logic [ADDR_W-1:0] a3, input logic [TNEW_W-1:0] tn,
                               input logic [ADDR_W-1:0] r);
    return (a3 != '0) && (a3 == r) && (tn == T_ZERO);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_e   <= '0;
      tnew_e <= '0;
      rs_e   <= '0;
      rt_e   <= '0;
      a3_m   <= '0;
      tnew_m <= '0;
      a3_w   <= '0;
      tnew_w <= '0;
    end else begin
      if (stall_D || flush_E) begin
        a3_e   <= '0;
        tnew_e <= '0;
        rs_e   <= '0;
        rt_e   <= '0;
      end else begin
        a3_e   <= a3_d;
        tnew_e <= tnew_d;
        rs_e   <= rs_d;
        rt_e   <= rt_d;
      end
      a3_m   <= a3_e;
      tnew_m <= age(tnew_e);
      a3_w   <= a3_m;
      tnew_w <= age(tnew_m);
    end
  end

  logic haz_rs, haz_rt;

  always_comb begin
    haz_rs = (tuse_rs != T_NONE) && (rs_d != '0) &&
             (((a3_e == rs_d) && (tnew_e > tuse_rs)) || ((a3_m == rs_d) && (tnew_m > tuse_rs)));
    haz_rt = (tuse_rt != T_NONE) && (rt_d != '0) &&
             (((a3_e == rt_d) && (tnew_e > tuse_rt)) || ((a3_m == rt_d) && (tnew_m > tuse_rt)));
    stall_D = reset && (haz_rs || haz_rt);
  end

  // Decode comes straight from Instr_D, so it is masked while reset is held.
  assign A3_D = reset ? a3_d : '0;

  always_comb begin
    fwd_rs_D = 2'd0;
    fwd_rt_D = 2'd0;
    fwd_rs_E = 2'd0;
    fwd_rt_E = 2'd0;
    if (hit(a3_e, tnew_e, rs_d))      fwd_rs_D = 2'd3;
    else if (hit(a3_m, tnew_m, rs_d)) fwd_rs_D = 2'd2;
    else if (hit(a3_w, tnew_w, rs_d)) fwd_rs_D = 2'd1;
    if (hit(a3_e, tnew_e, rt_d))      fwd_rt_D = 2'd3;
    else if (hit(a3_m, tnew_m, rt_d)) fwd_rt_D = 2'd2;
    else if (hit(a3_w, tnew_w, rt_d)) fwd_rt_D = 2'd1;
    if (hit(a3_m, tnew_m, rs_e))      fwd_rs_E = 2'd2;
    else if (hit(a3_w, tnew_w, rs_e)) fwd_rs_E = 2'd1;
    if (hit(a3_m, tnew_m, rt_e))      fwd_rt_E = 2'd2;
    else if (hit(a3_w, tnew_w, rt_e)) fwd_rt_E = 2'd1;
  end

`ifdef CTRL_HAZ_STATS_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (stall_D && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ctrl_hazard_unit.sv
// tb/tb_ctrl_hazard_unit.sv - vector table, corner sequences and randomized model check for ctrl_hazard_unit.
module tb_ctrl_hazard_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instr_D = 32'd0;
  logic        flush_E = 1'b0;
  logic        stall_D;
  logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [4:0]  A3_D;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  ctrl_hazard_unit dut (
    .clk(clk), .reset(reset), .Instr_D(Instr_D), .flush_E(flush_E),
    .stall_D(stall_D), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .A3_D(A3_D), .stall_cnt(stall_cnt)
  );

  int nvec = 0;
  int nerr = 0;

  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;

  // Each in-flight writer is tracked by its total latency; readiness follows from its age.
  typedef struct { logic [4:0] a3; int lat; logic [4:0] rs; logic [4:0] rt; } slot_t;
  typedef struct { int tuse_rs; int tuse_rt; int lat; logic [4:0] a3; } dec_t;

  slot_t      stg [3];
  int         m_cnt;
  logic       m_stall;
  logic [1:0] m_frsd, m_frtd, m_frse, m_frte;
  logic [4:0] m_a3;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  function automatic logic [31:0] LW(input logic [4:0] rt, input logic [4:0] b);
    return itype(6'h23, b, rt);
  endfunction
  function automatic logic [31:0] ADDU(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return rtype(6'h21, rs, rt, rd);
  endfunction
  function automatic logic [31:0] BEQ(input logic [4:0] rs, input logic [4:0] rt);
    return itype(6'h04, rs, rt);
  endfunction
  function automatic logic [31:0] JR(input logic [4:0] rs);
    return rtype(6'h08, rs, 5'd0, 5'd0);
  endfunction

  localparam logic [31:0] NOP = 32'd0;
  localparam logic [31:0] JAL = {6'h03, 26'h0000010};
  localparam logic [31:0] UNK = {6'h3f, 5'd1, 5'd1, 16'd0};

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    logic [4:0] rt, rd;
    rt = ins[20:16];
    rd = ins[15:11];
    d = '{tuse_rs: -1, tuse_rt: -1, lat: 0, a3: 5'd0};
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h21 || ins[5:0] == 6'h23) d = '{1, 1, ALU_LAT, rd};
        else if (ins[5:0] == 6'h08) d.tuse_rs = 0;
        else if (ins[5:0] == 6'h09) d = '{0, -1, 0, rd};
      end
      6'h0d, 6'h08: d = '{1, -1, ALU_LAT, rt};
      6'h0f:        d = '{-1, -1, ALU_LAT, rt};
      6'h23:        d = '{1, -1, LOAD_LAT, rt};
      6'h2b:        d = '{1, 2, 0, 5'd0};
      6'h04, 6'h3c: d = '{0, 0, 0, 5'd0};
      6'h03:        d = '{-1, -1, 0, 5'd31};
      default: ;
    endcase
    return d;
  endfunction

  function automatic int tnew_at(input int k);
    return (stg[k].lat - k > 0) ? stg[k].lat - k : 0;
  endfunction

  function automatic logic haz(input logic [4:0] r, input int tuse);
    if (tuse < 0 || r == 5'd0) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (stg[k].a3 == r && tnew_at(k) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] r, input int first);
    for (int k = first; k < 3; k++)
      if (stg[k].a3 != 5'd0 && stg[k].a3 == r && tnew_at(k) == 0) return 2'(3 - k);
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) stg[k] = '{5'd0, 0, 5'd0, 5'd0};
    m_cnt = 0;
  endtask

  task automatic model_eval();
    dec_t d;
    d = decode(Instr_D);
    if (!reset) begin
      m_stall = 1'b0; m_frsd = 2'd0; m_frtd = 2'd0; m_frse = 2'd0; m_frte = 2'd0; m_a3 = 5'd0;
    end else begin
      m_stall = haz(Instr_D[25:21], d.tuse_rs) || haz(Instr_D[20:16], d.tuse_rt);
      m_frsd  = fsel(Instr_D[25:21], 0);
      m_frtd  = fsel(Instr_D[20:16], 0);
      m_frse  = fsel(stg[0].rs, 1);
      m_frte  = fsel(stg[0].rt, 1);
      m_a3    = d.a3;
    end
  endtask

  task automatic model_step();
    dec_t d;
    d = decode(Instr_D);
    if (!reset) begin
      model_reset();
    end else begin
      if (m_stall) m_cnt++;
      stg[2] = stg[1];
      stg[1] = stg[0];
      if (m_stall || flush_E) stg[0] = '{5'd0, 0, 5'd0, 5'd0};
      else stg[0] = '{d.a3, d.lat, Instr_D[25:21], Instr_D[20:16]};
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int c);
`ifdef CTRL_HAZ_STATS_EN
    return 32'(c);
`else
    return (c < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic fl);
    @(negedge clk);
    Instr_D = ins;
    flush_E = fl;
    #2;
    model_eval();
    chk("stall_cnt", stall_cnt, exp_cnt(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".stall_D"}, 32'(stall_D), 32'(m_stall));
    chk({tag, ".A3_D"}, 32'(A3_D), 32'(m_a3));
    chk({tag, ".fwd_rs_E"}, 32'(fwd_rs_E), 32'(m_frse));
    chk({tag, ".fwd_rt_E"}, 32'(fwd_rt_E), 32'(m_frte));
    if (!m_stall) begin
      chk({tag, ".fwd_rs_D"}, 32'(fwd_rs_D), 32'(m_frsd));
      chk({tag, ".fwd_rt_D"}, 32'(fwd_rt_D), 32'(m_frtd));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    Instr_D = NOP;
    flush_E = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #2;
    model_eval();
    tick();
  endtask

  typedef struct {
    logic [31:0] ins; logic fl; logic st;
    logic [1:0] rsd; logic [1:0] rtd; logic [1:0] rse; logic [1:0] rte; logic [4:0] a3;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [31:0] ins;
    logic [4:0]  ra, rb, rc;
    logic        hold;

    tbl[0]  = '{LW(1, 0),       0, 0, 0, 0, 0, 0, 5'd1};
    tbl[1]  = '{ADDU(2, 1, 3),  0, 1, 0, 0, 0, 0, 5'd2};
    tbl[2]  = '{ADDU(2, 1, 3),  0, 0, 0, 0, 0, 0, 5'd2};
    tbl[3]  = '{NOP,            0, 0, 0, 0, 1, 0, 5'd0};
    tbl[4]  = '{NOP,            0, 0, 0, 0, 0, 0, 5'd0};
    tbl[5]  = '{LW(1, 0),       0, 0, 0, 0, 0, 0, 5'd1};
    tbl[6]  = '{BEQ(1, 0),      0, 1, 0, 0, 0, 0, 5'd0};
    tbl[7]  = '{BEQ(1, 0),      0, 1, 0, 0, 0, 0, 5'd0};
    tbl[8]  = '{BEQ(1, 0),      0, 0, 1, 0, 0, 0, 5'd0};
    tbl[9]  = '{JAL,            0, 0, 0, 0, 0, 0, 5'd31};
    tbl[10] = '{JR(31),         0, 0, 3, 0, 0, 0, 5'd0};
    tbl[11] = '{ADDU(0, 1, 2),  0, 0, 0, 0, 2, 0, 5'd0};
    tbl[12] = '{ADDU(3, 0, 0),  0, 0, 0, 0, 0, 0, 5'd3};
    tbl[13] = '{UNK,            0, 0, 0, 0, 0, 0, 5'd0};

    // Outputs must read zero while reset is held, even with a writer in D.
    model_reset();
    Instr_D = LW(1, 0);
    #12;
    chk("rst.stall_D", 32'(stall_D), 32'd0);
    chk("rst.A3_D", 32'(A3_D), 32'd0);
    chk("rst.fwd", 32'({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E}), 32'd0);
    chk("rst.stall_cnt", stall_cnt, 32'd0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ins, tbl[i].fl);
      chk($sformatf("v%0d.stall_D", i), 32'(stall_D), 32'(tbl[i].st));
      chk($sformatf("v%0d.A3_D", i), 32'(A3_D), 32'(tbl[i].a3));
      chk($sformatf("v%0d.fwd_rs_E", i), 32'(fwd_rs_E), 32'(tbl[i].rse));
      chk($sformatf("v%0d.fwd_rt_E", i), 32'(fwd_rt_E), 32'(tbl[i].rte));
      if (!tbl[i].st) begin
        chk($sformatf("v%0d.fwd_rs_D", i), 32'(fwd_rs_D), 32'(tbl[i].rsd));
        chk($sformatf("v%0d.fwd_rt_D", i), 32'(fwd_rt_D), 32'(tbl[i].rtd));
      end
      tick();
    end

    // Load-use branch scenario twice from a clean reset: four stall cycles.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      drive(LW(1, 0), 0); tick();
      for (int b = 0; b < 3; b++) begin drive(BEQ(1, 0), 0); chk_model("lwbeq"); tick(); end
    end
    drive(NOP, 0);
`ifdef CTRL_HAZ_STATS_EN
    chk("stats_x2", stall_cnt, 32'd4);
`else
    chk("stats_off", stall_cnt, 32'd0);
`endif
    tick();

    // Reset pulled mid-stall drops everything at once; E is empty afterwards.
    drive(LW(1, 0), 0); tick();
    drive(ADDU(2, 1, 1), 0);
    chk("midrst.pre_stall", 32'(stall_D), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst.stall_D", 32'(stall_D), 32'd0);
    chk("midrst.fwd", 32'({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E}), 32'd0);
    chk("midrst.A3_D", 32'(A3_D), 32'd0);
    tick();
    @(negedge clk);
    reset = 1'b1;
    #2;
    model_eval();
    chk("postrst.stall_D", 32'(stall_D), 32'd0);
    chk_model("postrst");
    tick();

    // Flush of a load removes the hazard it would have caused.
    drive(LW(1, 0), 1); tick();
    drive(ADDU(2, 1, 3), 0);
    chk("flush.stall_D", 32'(stall_D), 32'd0);
    chk_model("flush"); tick();

    // Flush coinciding with a stall yields a single bubble.
    drive(NOP, 0); tick();
    drive(LW(1, 0), 0); tick();
    drive(ADDU(2, 1, 3), 1);
    chk("fl_st.stall1", 32'(stall_D), 32'd1); tick();
    drive(ADDU(2, 1, 3), 0);
    chk("fl_st.stall2", 32'(stall_D), 32'd0); tick();
    drive(NOP, 0);
    chk("fl_st.fwd_rs_E", 32'(fwd_rs_E), 32'd1);
    chk_model("fl_st"); tick();

    hold = 1'b0;
    ins  = NOP;
    for (int c = 0; c < 500; c++) begin
      if (!hold) begin
        ra = 5'($urandom_range(0, 3));
        rb = 5'($urandom_range(0, 3));
        rc = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 14))
          0:  ins = ADDU(rc, ra, rb);
          1:  ins = rtype(6'h23, ra, rb, rc);
          2:  ins = itype(6'h0d, ra, rb);
          3:  ins = itype(6'h08, ra, rb);
          4:  ins = itype(6'h0f, ra, rb);
          5:  ins = LW(rb, ra);
          6:  ins = itype(6'h2b, ra, rb);
          7:  ins = BEQ(ra, rb);
          8:  ins = itype(6'h3c, ra, rb);
          9:  ins = JR(($urandom_range(0, 1) == 1) ? 5'd31 : ra);
          10: ins = rtype(6'h09, ($urandom_range(0, 1) == 1) ? 5'd31 : ra, 5'd0, rc);
          11: ins = JAL;
          12: ins = {6'h02, 26'h0000100};
          13: ins = NOP;
          default: ins = {6'h3f, ra, rb, 16'd0};
        endcase
      end
      drive(ins, ($urandom_range(0, 7) == 0));
      chk_model($sformatf("rnd%0d", c));
      hold = m_stall;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
